// File: rtl/cnn_fc_pkg.sv
// Shared sizes, limits and FSM encoding for the
// fully-connected argmax head of the CNN pipeline.
package cnn_fc_pkg;

  localparam int N_FEAT  = 4;
  localparam int N_CLASS = 3;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 34;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    16'sh7fff;
  localparam logic signed [DATA_W-1:0] SAT_MIN =
    16'sh8000;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    34'sd32767;
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    -34'sd32768;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMPUTE,
    OUT
  } state_e;

endpackage

// File: rtl/cnn_fc_mac.sv
// One signed multiply-accumulate step with the
// running sum also clamped to a 16-bit score.
module cnn_fc_mac
  import cnn_fc_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic signed [DATA_W-1:0] sat_o
);

  logic signed [2*DATA_W-1:0] prod;

  // product, sign-extended add, clamp
  always_comb begin
    prod  = a_i * b_i;
    sum_o = acc_i + $signed(
      {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}},
       prod});
    if (sum_o > ACC_MAX) begin
      sat_o = SAT_MAX;
    end else if (sum_o < ACC_MIN) begin
      sat_o = SAT_MIN;
    end else begin
      sat_o = sum_o[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/cnn_fc_argmax.sv
// Collects one frame of pooled features, runs a
// serial FC layer and reports the winning class.
module cnn_fc_argmax
  import cnn_fc_pkg::*;
#(
  parameter int N_FEAT  = cnn_fc_pkg::N_FEAT,
  parameter int N_CLASS = cnn_fc_pkg::N_CLASS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        w_we,
  input  logic [3:0]  w_addr,
  input  logic [15:0] w_data,
  output logic        out_valid,
  output logic [1:0]  out_class,
  output logic [15:0] out_score,
  output logic        drop
);

  localparam int NW  = N_FEAT * N_CLASS;
  localparam int FW  =
    (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CW  = $clog2(N_CLASS + 1);
  localparam int WAW =
    (NW > 1) ? $clog2(NW) : 1;

  state_e state_q, state_d;

  logic [FW-1:0] f_cnt_q, f_cnt_d;
  logic [FW-1:0] mf_q, mf_d;
  logic [CW-1:0] mc_q, mc_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]  best_c_q, best_c_d;
  logic signed [DATA_W-1:0] best_s_q, best_s_d;

  logic signed [DATA_W-1:0] feat_q [N_FEAT];
  logic signed [DATA_W-1:0] feat_d [N_FEAT];
  logic signed [DATA_W-1:0] w_q [NW];
  logic signed [DATA_W-1:0] w_d [NW];

  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_class_q, out_class_d;
  logic [15:0] out_score_q, out_score_d;

  logic open_win;
  logic accept;
  logic last_feat;
  logic wr_ok;
  logic mac_done;
  logic mac_run;
  logic mac_last;
  logic out_load;

  logic [WAW-1:0] w_idx;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [DATA_W-1:0] mac_sat;

  // Feature/weight loading is open only between
  // frames; the MAC walks class-major, and one
  // trailing COMPUTE cycle drains the last argmax.
  always_comb begin
    open_win  = (state_q == IDLE) ||
                (state_q == COLLECT);
    accept    = in_valid && open_win;
    last_feat = f_cnt_q == FW'(N_FEAT - 1);
    wr_ok     = w_we && open_win &&
                ({28'd0, w_addr} < NW);
    mac_done  = mc_q == CW'(N_CLASS);
    mac_run   = (state_q == COMPUTE) &&
                !mac_done;
    mac_last  = mf_q == FW'(N_FEAT - 1);
    w_idx     = WAW'(int'(mc_q) * N_FEAT +
                     int'(mf_q));
    mac_acc   = (mf_q == '0) ? '0 : acc_q;
  end

  cnn_fc_mac u_mac (
    .a_i   (feat_q[mf_q]),
    .b_i   (w_q[w_idx]),
    .acc_i (mac_acc),
    .sum_o (mac_sum),
    .sat_o (mac_sat)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = last_feat ? COMPUTE
                              : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && last_feat) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (mac_done) begin
          state_d = OUT;
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: result load and drop strobe
  always_comb begin
    out_load = (state_q == COMPUTE) && mac_done;
    drop     = in_valid && !open_win;
  end

  // datapath next-state
  always_comb begin
    f_cnt_d  = f_cnt_q;
    mf_d     = mf_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    best_c_d = best_c_q;
    best_s_d = best_s_q;
    feat_d   = feat_q;
    w_d      = w_q;

    if (accept) begin
      feat_d[f_cnt_q] = in_data;
      f_cnt_d = last_feat ? '0
                          : f_cnt_q + 1'b1;
    end

    if (wr_ok) begin
      w_d[w_addr[WAW-1:0]] = w_data;
    end

    if (mac_run) begin
      acc_d = mac_sum;
      if (mac_last) begin
        mf_d = '0;
        mc_d = mc_q + 1'b1;
        if ((mc_q == '0) ||
            (mac_sat > best_s_q)) begin
          best_c_d = 2'(mc_q);
          best_s_d = mac_sat;
        end
      end else begin
        mf_d = mf_q + 1'b1;
      end
    end

    if (state_q == OUT) begin
      mc_d     = '0;
      acc_d    = '0;
      best_c_d = '0;
      best_s_d = '0;
    end

    out_valid_d = out_load;
    out_class_d = out_load ? best_c_q : '0;
    out_score_d = out_load ? best_s_q : '0;
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt_q     <= '0;
      mf_q        <= '0;
      mc_q        <= '0;
      acc_q       <= '0;
      best_c_q    <= '0;
      best_s_q    <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      for (int i = 0; i < N_FEAT; i++) begin
        feat_q[i] <= '0;
      end
      for (int i = 0; i < NW; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      f_cnt_q     <= f_cnt_d;
      mf_q        <= mf_d;
      mc_q        <= mc_d;
      acc_q       <= acc_d;
      best_c_q    <= best_c_d;
      best_s_q    <= best_s_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      feat_q      <= feat_d;
      w_q         <= w_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;

endmodule

// File: tb/tb_cnn_fc_argmax.sv
// Directed frames with a scoreboard of expected
// class/score/arrival-cycle for cnn_fc_argmax.
module tb_cnn_fc_argmax;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        out_valid;
  logic [1:0]  out_class;
  logic [15:0] out_score;
  logic        drop;

  cnn_fc_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_score (out_score),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  cls;
    logic [15:0] score;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid",
                64'(out_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_class", 64'(out_class),
                64'(mon_e.cls));
          check("out_score", 64'(out_score),
                64'(mon_e.score));
          check("latency", 64'(cyc),
                64'(mon_e.at));
        end
      end else begin
        check("idle_class", 64'(out_class), 0);
        check("idle_score", 64'(out_score), 0);
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = 16'(d);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic set_w(input int v0,
                       input int v1,
                       input int v2);
    int v[3];
    v = '{v0, v1, v2};
    for (int c = 0; c < 3; c++) begin
      for (int f = 0; f < 4; f++) begin
        wr(c * 4 + f, v[c]);
      end
    end
  endtask

  task automatic send(input int a, input int b,
                      input int c, input int d,
                      input int gap,
                      input bit ex,
                      input int ecls,
                      input int escore,
                      input bit wen,
                      input int wa,
                      input int wd);
    int f[4];
    f = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(f[i]);
      w_we     = 1'b0;
      if (i == 0 && wen) begin
        w_we   = 1'b1;
        w_addr = 4'(wa);
        w_data = 16'(wd);
      end
      if (i == 3 && ex) begin
        sb.push_back('{2'(ecls), 16'(escore),
                       cyc + 14});
      end
      #1 check("drop_accept", 64'(drop), 0);
      if (gap > 0 && i < 3) begin
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_we     = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("result_timeout", 64'(sb.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic drop_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h7fff;
      #1 check("drop_compute", 64'(drop), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_class", 64'(out_class), 0);
    check("rst_score", 64'(out_score), 0);
    check("rst_drop",  64'(drop), 0);
    rst = 1'b0;

    // scores 10,20,30
    set_w(1, 2, 3);
    send(1, 2, 3, 4, 0, 1, 2, 30, 0, 0, 0);
    wait_out();

    // tie between class 0 and 1 at 5
    wr(0, 5);
    wr(4, 5);
    wr(8, -1);
    send(1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0);
    wait_out();

    // positive saturation on class 1
    set_w(0, 32767, 0);
    send(32767, 32767, 32767, 32767,
         0, 1, 1, 32767, 0, 0, 0);
    wait_out();

    // all classes clamp to min, class 0 kept
    set_w(-32768, -32768, -32768);
    send(32767, 32767, 32767, 32767,
         0, 1, 0, -32768, 0, 0, 0);
    wait_out();

    // gapped frame, then drops in COMPUTE
    set_w(1, 2, 3);
    send(1, 2, 3, 4, 2, 1, 2, 30, 0, 0, 0);
    wait_out();
    send(1, 2, 3, 4, 0, 1, 2, 30, 0, 0, 0);
    drop_burst(3);
    wait_out();

    // write during COMPUTE is ignored
    send(1, 2, 3, 4, 0, 1, 2, 30, 0, 0, 0);
    wr(0, 100);
    wait_out();

    // same write in IDLE lands: 100+2+3+4
    wr(0, 100);
    send(1, 2, 3, 4, 0, 1, 0, 109, 0, 0, 0);
    wait_out();

    // out-of-range addresses are ignored
    for (int a = 12; a < 16; a++) begin
      wr(a, 16'h7fff);
    end
    send(1, 2, 3, 4, 0, 1, 0, 109, 0, 0, 0);
    wait_out();

    // reset after the 2nd feature
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd100;
    @(negedge clk);
    in_data  = 16'd100;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("arst_valid", 64'(out_valid), 0);
    check("arst_drop", 64'(drop), 0);
    @(negedge clk);
    rst = 1'b0;

    // weights were cleared: w0 stays 0 and
    // w11 arrives together with feature 0
    for (int a = 1; a < 11; a++) begin
      wr(a, a / 4 + 1);
    end
    send(1, 2, 3, 4, 0, 1, 2, 30, 1, 11, 3);
    wait_out();

    // reset mid-COMPUTE abandons the frame
    send(1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abandoned_queue", 64'(sb.size()), 0);
    check("final_valid", 64'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cnn_fc_argmax.md
CNN_FC_ARGMAX -- requirements
Module: cnn_fc_argmax

Interface
REQ-001 SHALL have parameter N_FEAT, default 4, number of pooled features per frame.
REQ-002 SHALL have parameter N_CLASS, default 3, number of output classes.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  feature strobe; connects to the CNN stage out_valid.
REQ-006 SHALL have port in_data  input  16  signed feature; connects to the CNN stage out_data.
REQ-007 SHALL have port w_we  input  1  weight write enable.
REQ-008 SHALL have port w_addr  input  4  weight index, class*N_FEAT+feature.
REQ-009 SHALL have port w_data  input  16  signed weight.
REQ-010 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port out_class  output  2  winning class index.
REQ-012 SHALL have port out_score  output  16  signed saturated winning score.
REQ-013 SHALL have port drop  output  1  one-cycle pulse when an in_valid sample is discarded.

Function
REQ-014 SHALL implement states IDLE, COLLECT, COMPUTE, OUT.
REQ-015 In IDLE or COLLECT, each in_valid cycle SHALL store in_data at feature index f_cnt and increment f_cnt.
REQ-016 The first accepted sample SHALL move IDLE to COLLECT.
REQ-017 in_valid low cycles inside a frame SHALL hold f_cnt; the frame continues with no timeout.
REQ-018 Accepting feature N_FEAT-1 SHALL move the FSM to COMPUTE with f_cnt cleared.
REQ-019 COMPUTE SHALL perform exactly one signed 16x16 multiply-accumulate per cycle, in order class 0..2, feature 0..3, for N_FEAT*N_CLASS = 12 cycles.
REQ-020 The accumulator SHALL be 34-bit signed and SHALL be cleared at the start of each class.
REQ-021 Each class score SHALL be the accumulator saturated to 16-bit signed: max 32767, min -32768.
REQ-022 Argmax SHALL replace the running best only on strictly greater score, so ties keep the lower index.
REQ-023 Class 0 SHALL always initialise the running best.
REQ-024 After the 12th MAC cycle, the FSM SHALL enter OUT for exactly one cycle, then return to IDLE.
REQ-025 out_valid SHALL be high exactly during OUT, with registered out_class/out_score; both SHALL read 0 whenever out_valid is low.
REQ-026 Latency SHALL be fixed: 4th feature accepted at edge T -> out_valid high in the cycle following edge T+13.
REQ-027 in_valid during COMPUTE or OUT SHALL be discarded, pulsing drop for that cycle; the next frame starts from the first in_valid in IDLE.
REQ-028 Weight writes SHALL take effect only in IDLE or COLLECT.
REQ-029 Writes in COMPUTE/OUT SHALL be ignored, so weights are stable during a computation.
REQ-030 w_addr >= N_FEAT*N_CLASS SHALL be ignored.
REQ-031 A simultaneous w_we and in_valid SHALL both be honoured.

Reset
REQ-032 rst high SHALL asynchronously force state IDLE, f_cnt 0, accumulator 0, best 0, out_valid 0, out_class 0, out_score 0, drop 0.
REQ-033 Reset SHALL clear all feature registers to 0.
REQ-034 Weight registers SHALL reset to 0.
REQ-035 Reset mid-COLLECT or mid-COMPUTE SHALL abandon the frame, with no out_valid afterwards for it.

Structure
REQ-036 A package cnn_fc_pkg SHALL hold N_FEAT, N_CLASS, DATA_W=16, ACC_W=34, the state enum, and the SAT16 limits.
REQ-037 One sub-module, cnn_fc_mac, SHALL be used: combinational 16x16 signed multiply plus 34-bit add, with a saturate-to-16 output.
REQ-038 All other logic SHALL reside in cnn_fc_argmax.

Verification
REQ-039 Scenario 1: weights class c = all (c+1); features 1,2,3,4 contiguous -> scores 10,20,30 -> out_class 2, out_score 30, at T+13.
REQ-040 Scenario 2: features 1,0,0,0 with weights w0=5, w4=5, w8=-1 (tie) -> out_class 0, out_score 5.
REQ-041 Scenario 3: features all 32767, class 1 weights 32767, others 0 -> out_class 1, out_score 32767 (saturated); negative overflow on class 0 -> score -32768.
REQ-042 Scenario 4: frame with in_valid gaps of 2 cycles between features -> same result as contiguous; in_valid during COMPUTE -> drop pulses, result unchanged.
REQ-043 Scenario 5: w_we during COMPUTE to w_addr 0 -> current result unaffected; same write in IDLE -> used by next frame; w_addr 12..15 -> no effect.
REQ-044 Scenario 6: rst pulse after 2nd feature, then a full frame -> exactly one out_valid, computed from the new frame only.
